ram_in_loader: RTL and testbench



---
 rtl/ram_in_loader.sv | 139 +++++++++++++
 tb/tb_ram_in_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_in_loader.sv
// Purpose: feeds DEPTH-byte frames from a valid/ready byte stream into the core's input RAM, then pulses start and waits for done.
// Latency: a write appears the cycle after its byte is accepted; start is high two cycles after the last byte is accepted.
// Backpressure: s_ready is high only in LOAD, so the stream is held off from the last byte of a frame until done (or timeout).
//
// Ports: clk/rst_n (async active-low reset); s_valid/s_data/s_ready stream in;
//        ram_in_we/ram_in_addr_wr/ram_in_data_wr registered RAM write port;
//        start one-cycle pulse to the core; done from the core; busy high in FIRE/WAIT;
//        frame_cnt completed frames (8-bit wrap); err one-cycle timeout pulse.
// Optional: define LOADER_TIMEOUT_EN to abandon WAIT after TIMEOUT cycles without done.
module ram_in_loader #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ram_in_we,
    output logic [ADDR_W-1:0] ram_in_addr_wr,
    output logic [DATA_W-1:0] ram_in_data_wr,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FIRE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              start_q, start_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    logic              xfer;
    logic              last_byte;
    logic              timeout_hit;

    assign xfer      = s_valid && s_ready;
    assign last_byte = (ptr_q == ADDR_W'(DEPTH - 1));

`ifdef LOADER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    // Reaching TIMEOUT-1 on a done-less WAIT cycle means this is the
    // TIMEOUT-th such cycle; done on the same cycle takes priority.
    assign timeout_hit = (state_q == ST_WAIT) && !done &&
                         (wcnt_q == WCNT_W'(TIMEOUT - 1));

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == ST_FIRE)
            wcnt_d = '0;
        else if ((state_q == ST_WAIT) && !done)
            wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt_q <= '0;
        else        wcnt_q <= wcnt_d;
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; done is only looked at in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: if (xfer && last_byte) state_d = ST_FIRE;
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: if (done || timeout_hit) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = (state_q == ST_LOAD);
        busy    = (state_q == ST_FIRE) || (state_q == ST_WAIT);
    end

    // Registered write port, pointer, start pulse and frame counter
    always_comb begin
        we_d        = xfer;
        addr_d      = xfer ? ptr_q  : addr_q;
        data_d      = xfer ? s_data : data_q;
        // DEPTH is a power of two, so the pointer wraps to 0 after the last byte
        ptr_d       = xfer ? ptr_q + 1'b1 : ptr_q;
        start_d     = (state_q == ST_FIRE);
        frame_cnt_d = ((state_q == ST_WAIT) && done) ? frame_cnt_q + 8'd1 : frame_cnt_q;
        err_d       = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            start_q     <= start_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign ram_in_we      = we_q;
    assign ram_in_addr_wr = addr_q;
    assign ram_in_data_wr = data_q;
    assign start          = start_q;
    assign frame_cnt      = frame_cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ram_in_loader.sv
// Bench for ram_in_loader: frame vectors from a table, write scoreboard checked on the falling edge,
// hand-written sequences for reset mid-frame, frame counter wrap and (when enabled) timeout.
module tb_ram_in_loader;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       ram_in_we;
    logic [1:0] ram_in_addr_wr;
    logic [7:0] ram_in_data_wr;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       err;

    ram_in_loader #(.DEPTH(4), .ADDR_W(2), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .ram_in_we      (ram_in_we),
        .ram_in_addr_wr (ram_in_addr_wr),
        .ram_in_data_wr (ram_in_data_wr),
        .start          (start),
        .done           (done),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [9:0] wr_q[$];   // expected {addr, data} per RAM write

    // done_mode: 0 = pulse after wait_cyc extra WAIT cycles, 1 = held high the whole frame,
    //            2 = one-cycle pulse on the first WAIT cycle
    typedef struct {
        logic [31:0] bytes;     // byte 0 in [31:24]
        int          gap;       // s_valid low cycles between bytes 1 and 2
        int          done_mode;
        int          wait_cyc;
        logic [7:0]  exp_cnt;   // frame_cnt expected after done
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port and start monitor
    always @(negedge clk) begin
        if (rst_n && ram_in_we) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h want no write", ram_in_addr_wr, ram_in_data_wr);
            end else begin
                logic [9:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", {30'd0, ram_in_addr_wr}, {30'd0, e[9:8]});
                chk("wr_data", {24'd0, ram_in_data_wr}, {24'd0, e[7:0]});
            end
        end
        if (rst_n && start) start_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic [1:0] a);
        s_valid = 1'b1;
        s_data  = d;
        chk("s_ready_load", {31'd0, s_ready}, 32'd1);
        wr_q.push_back({a, d});
        tick();
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic run_frame(input vec_t v);
        int s0;
        logic [7:0] b;
        s0 = start_cnt;
        if (v.done_mode == 1) done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < v.gap; g++) begin
                    s_valid = 1'b0;
                    chk("s_ready_gap", {31'd0, s_ready}, 32'd1);
                    tick();
                end
            end
            b = v.bytes[31 - 8*i -: 8];
            send_byte(b, 2'(i));
        end
        // FIRE: last write visible, no start yet, count unchanged
        chk("fire_s_ready", {31'd0, s_ready}, 32'd0);
        chk("fire_busy",    {31'd0, busy},    32'd1);
        chk("fire_start",   {31'd0, start},   32'd0);
        chk("fire_we",      {31'd0, ram_in_we}, 32'd1);
        chk("fire_addr",    {30'd0, ram_in_addr_wr}, 32'd3);
        chk("fire_cnt",     {24'd0, frame_cnt}, {24'd0, 8'(v.exp_cnt - 8'd1)});
        tick();
        // first WAIT cycle
        chk("wait_start",   {31'd0, start},   32'd1);
        chk("wait_s_ready", {31'd0, s_ready}, 32'd0);
        chk("wait_busy",    {31'd0, busy},    32'd1);
        if (v.done_mode == 0) begin
            for (int k = 0; k < v.wait_cyc; k++) begin
                tick();
                chk("wait_start_low", {31'd0, start},   32'd0);
                chk("wait_hold",      {31'd0, s_ready}, 32'd0);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("post_s_ready",  {31'd0, s_ready}, 32'd1);
        chk("post_busy",     {31'd0, busy},    32'd0);
        chk("post_cnt",      {24'd0, frame_cnt}, {24'd0, v.exp_cnt});
        chk("start_pulses",  start_cnt - s0, 32'd1);
        chk("writes_drained", wr_q.size(), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{bytes: 32'h24810963, gap: 0, done_mode: 0, wait_cyc: 3, exp_cnt: 8'd1};
        vecs[1] = '{bytes: 32'h24810963, gap: 3, done_mode: 0, wait_cyc: 2, exp_cnt: 8'd2};
        vecs[2] = '{bytes: 32'hA55AFF00, gap: 0, done_mode: 1, wait_cyc: 0, exp_cnt: 8'd3};
        vecs[3] = '{bytes: 32'h01020480, gap: 1, done_mode: 2, wait_cyc: 0, exp_cnt: 8'd4};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        done    = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_we",      {31'd0, ram_in_we}, 32'd0);
        chk("rst_addr",    {30'd0, ram_in_addr_wr}, 32'd0);
        chk("rst_data",    {24'd0, ram_in_data_wr}, 32'd0);
        chk("rst_start",   {31'd0, start}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_cnt",     {24'd0, frame_cnt}, 32'd0);
        chk("rst_err",     {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
        tick();

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Reset after two accepted bytes discards the partial frame
        send_byte(8'h11, 2'd0);
        send_byte(8'h22, 2'd1);
        tick();
        chk("partial_drained", wr_q.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",      {31'd0, ram_in_we}, 32'd0);
        chk("mid_rst_addr",    {30'd0, ram_in_addr_wr}, 32'd0);
        chk("mid_rst_data",    {24'd0, ram_in_data_wr}, 32'd0);
        chk("mid_rst_start",   {31'd0, start}, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_busy",    {31'd0, busy}, 32'd0);
        chk("mid_rst_cnt",     {24'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("mid_idle_s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        v = '{bytes: 32'h3C4D5E6F, gap: 0, done_mode: 2, wait_cyc: 0, exp_cnt: 8'd1};
        run_frame(v);

        // Drive frame_cnt through 255 -> 0
        for (int f = 2; f <= 256; f++) begin
            v = '{bytes: $urandom, gap: 0, done_mode: 2, wait_cyc: 0, exp_cnt: 8'(f)};
            run_frame(v);
        end
        chk("cnt_wrapped", {24'd0, frame_cnt}, 32'd0);
        chk("err_idle", {31'd0, err}, 32'd0);

`ifdef LOADER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 2'(i));
        tick();
        for (int k = 0; k < TMO; k++) begin
            chk("to_err_low",  {31'd0, err},     32'd0);
            chk("to_s_ready0", {31'd0, s_ready}, 32'd0);
            tick();
        end
        chk("to_err_pulse", {31'd0, err},     32'd1);
        chk("to_s_ready1",  {31'd0, s_ready}, 32'd1);
        chk("to_cnt",       {24'd0, frame_cnt}, 32'd0);
        tick();
        chk("to_err_end",   {31'd0, err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
